// File: rtl/calc_core_param_if.sv
// Keypad/button inputs and display/status outputs of the hex calculator core.
// The master side drives btnc/val; the slave side (core) drives everything else.
interface calc_core_param_if #(
   parameter int W = 16
);
   logic         btnc;
   logic [4:0]   val;
   logic [W-1:0] canal_pantalla;
   logic [1:0]   estado;
   logic [2:0]   op;
   logic [W-1:0] op1;
   logic [W-1:0] op2;
   logic         carry;
   logic         res_valid;

   modport master (
      output btnc, val,
      input  canal_pantalla, estado, op, op1, op2, carry, res_valid
   );

   modport slave (
      input  btnc, val,
      output canal_pantalla, estado, op, op1, op2, carry, res_valid
   );
endinterface

// File: rtl/calc_core_param.sv
// Hex calculator: A entry, B entry, operator select, result display; one key per press edge.
// Result registered on the EXE press leaving OPSEL (1 cycle); no backpressure, presses are never stalled.
module calc_core_param #(
   parameter int W = 16
) (
   input  logic             clk,
   input  logic             rst,
   calc_core_param_if.slave bus
);
   localparam int DIGITS = W / 4;
   localparam int CW     = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] DIG_MAX = CW'(DIGITS);
   localparam logic [W-1:0]  W_LIM   = W'(W);

   typedef enum logic [1:0] {
      ENT_A = 2'd0,
      ENT_B = 2'd1,
      OPSEL = 2'd2,
      SHOW  = 2'd3
   } state_t;

   state_t        state, state_n;
   logic          btn_q;
   logic [W-1:0]  op1, op1_n;
   logic [W-1:0]  op2, op2_n;
   logic [2:0]    op, op_n;
   logic [W-1:0]  result, result_n;
   logic          carry, carry_n;
   logic [CW-1:0] cnt_a, cnt_a_n;
   logic [CW-1:0] cnt_b, cnt_b_n;

   logic          press;
   logic          key_dig, key_bksp, key_exe, key_clr, key_op;
   logic          do_clr, seed_digit;
   logic [W:0]    sum;
   logic [W-1:0]  alu_res;
   logic          alu_c;

   assign press    = bus.btnc & ~btn_q;
   assign key_dig  = (bus.val[4] == 1'b0);
   assign key_bksp = (bus.val == 5'h12);
   assign key_exe  = (bus.val == 5'h13);
   assign key_clr  = (bus.val == 5'h14);
   assign key_op   = (bus.val[4:3] == 2'b00);

   assign sum = {1'b0, op1} + {1'b0, op2};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      unique case (op)
         3'd0: {alu_c, alu_res} = sum;
         3'd1: begin
            alu_res = op1 - op2;
            alu_c   = (op1 < op2);
         end
         3'd2: alu_res = op1 & op2;
         3'd3: alu_res = op1 | op2;
         3'd4: alu_res = op1 ^ op2;
         3'd5: alu_res = (op2 >= W_LIM) ? '0 : (op1 << op2);
         3'd6: alu_res = (op2 >= W_LIM) ? '0 : (op1 >> op2);
         3'd7: alu_res = ~op1;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_n    = state;
      op1_n      = op1;
      op2_n      = op2;
      op_n       = op;
      result_n   = result;
      carry_n    = carry;
      cnt_a_n    = cnt_a;
      cnt_b_n    = cnt_b;
      do_clr     = 1'b0;
      seed_digit = 1'b0;

      if (press) begin
         unique case (state)
            ENT_A, ENT_B: begin
               if (key_clr) begin
                  do_clr = 1'b1;
               end else if (key_dig) begin
                  // Digits beyond the operand width saturate rather than wrap.
                  if (state == ENT_A) begin
                     if (cnt_a != DIG_MAX) begin
                        op1_n   = {op1[W-5:0], bus.val[3:0]};
                        cnt_a_n = cnt_a + CW'(1);
                     end
                  end else begin
                     if (cnt_b != DIG_MAX) begin
                        op2_n   = {op2[W-5:0], bus.val[3:0]};
                        cnt_b_n = cnt_b + CW'(1);
                     end
                  end
               end else if (key_bksp) begin
                  if (state == ENT_A) begin
                     if (cnt_a != '0) begin
                        op1_n   = op1 >> 4;
                        cnt_a_n = cnt_a - CW'(1);
                     end
                  end else begin
                     if (cnt_b != '0) begin
                        op2_n   = op2 >> 4;
                        cnt_b_n = cnt_b - CW'(1);
                     end
                  end
               end else if (key_exe) begin
                  state_n = (state == ENT_A) ? ENT_B : OPSEL;
               end
            end
            OPSEL: begin
               if (key_op) begin
                  op_n = bus.val[2:0];
               end else if (key_exe) begin
                  result_n = alu_res;
                  carry_n  = alu_c;
                  state_n  = SHOW;
               end else if (key_clr) begin
                  do_clr = 1'b1;
               end
            end
            SHOW: begin
               if (key_exe) begin
                  // Chain: result becomes a fully-entered A, operator kept.
                  op1_n   = result;
                  cnt_a_n = DIG_MAX;
                  op2_n   = '0;
                  cnt_b_n = '0;
                  state_n = ENT_B;
               end else if (key_dig) begin
                  do_clr     = 1'b1;
                  seed_digit = 1'b1;
               end else if (key_clr) begin
                  do_clr = 1'b1;
               end
            end
            default: state_n = ENT_A;
         endcase
      end

      if (do_clr) begin
         state_n  = ENT_A;
         op1_n    = '0;
         op2_n    = '0;
         op_n     = '0;
         result_n = '0;
         carry_n  = 1'b0;
         cnt_a_n  = '0;
         cnt_b_n  = '0;
         if (seed_digit) begin
            op1_n   = W'(bus.val[3:0]);
            cnt_a_n = CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // A button held through reset must not register as a press.
         btn_q  <= 1'b1;
         state  <= ENT_A;
         op1    <= '0;
         op2    <= '0;
         op     <= '0;
         result <= '0;
         carry  <= 1'b0;
         cnt_a  <= '0;
         cnt_b  <= '0;
      end else begin
         btn_q  <= bus.btnc;
         state  <= state_n;
         op1    <= op1_n;
         op2    <= op2_n;
         op     <= op_n;
         result <= result_n;
         carry  <= carry_n;
         cnt_a  <= cnt_a_n;
         cnt_b  <= cnt_b_n;
      end
   end

   always_comb begin
      bus.canal_pantalla = '0;
      unique case (state)
         ENT_A:   bus.canal_pantalla = op1;
         ENT_B:   bus.canal_pantalla = op2;
         OPSEL:   bus.canal_pantalla = {{(W-3){1'b0}}, op};
         SHOW:    bus.canal_pantalla = result;
         default: bus.canal_pantalla = '0;
      endcase
   end

   assign bus.estado    = state;
   assign bus.op        = op;
   assign bus.op1       = op1;
   assign bus.op2       = op2;
   assign bus.carry     = carry;
   assign bus.res_valid = (state == SHOW);
endmodule
